// File: rtl/ps2_pkg.sv
// Definitions shared by the PS/2 host transmitter and the keyboard receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_tx_state_e;

  // Host-to-device frame after the start bit: 8 data bits, parity, stop.
  localparam int unsigned PS2_FRAME_BITS = 10;

  // Bus register map.
  localparam logic ADDR_CTRL = 1'b0;
  localparam logic ADDR_DATA = 1'b1;

  // Status/control register bit positions.
  localparam int unsigned BIT_RDY = 0;
  localparam int unsigned BIT_IEN = 1;
  localparam int unsigned BIT_ERR = 2;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pads, plus a one-cycle
// falling-edge pulse on the synchronized clock.
module ps2_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic sync_clk,
  output logic sync_data,
  output logic fall
);

  logic [1:0] clk_ff;
  logic [1:0] data_ff;
  logic       prev_clk;

  // Idle bus is high, so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_ff   <= '1;
      data_ff  <= '1;
      prev_clk <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], ps2_clk_in};
      data_ff  <= {data_ff[0], ps2_data_in};
      prev_clk <= clk_ff[1];
    end
  end

  assign sync_clk  = clk_ff[1];
  assign sync_data = data_ff[1];
  assign fall      = prev_clk & ~clk_ff[1];

endmodule

// File: rtl/kbd_tx.sv
// PS/2 host-to-device transmitter with a two-register bus interface.
module kbd_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYC = 5000,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stb,
  input  logic       we,
  input  logic       addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       ack,
  output logic       irq,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_busy
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYC - 1);
  localparam logic [CW-1:0] TIMEOUT_VAL  = CW'(TIMEOUT_CYC);
  localparam logic [3:0]    LAST_BIT     = 4'(PS2_FRAME_BITS - 1);

  ps2_tx_state_e state, state_nxt;

  logic          rdy, ien, err;
  logic [7:0]    data_q;
  logic [9:0]    shreg;
  logic [3:0]    bitcnt;
  logic          data_bit;
  logic [CW-1:0] cnt;

  logic sync_clk, sync_data, fall;
  logic accept, ctrl_wr, watchdog, timeout, line_idle;

  ps2_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .sync_clk   (sync_clk),
    .sync_data  (sync_data),
    .fall       (fall)
  );

  assign accept    = stb & we & (addr == ADDR_DATA) & rdy;
  assign ctrl_wr   = stb & we & (addr == ADDR_CTRL);
  assign watchdog  = (state == ST_SHIFT) || (state == ST_ACK) || (state == ST_WAIT_IDLE);
  assign timeout   = watchdog && (cnt == TIMEOUT_VAL);
  assign line_idle = sync_clk & sync_data;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a watchdog expiry overrides every other transition.
  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:      if (accept) state_nxt = ST_INHIBIT;
        ST_INHIBIT:   if (cnt == INHIBIT_LAST) state_nxt = ST_REQ;
        ST_REQ:       state_nxt = ST_SHIFT;
        ST_SHIFT:     if (fall && (bitcnt == LAST_BIT)) state_nxt = ST_ACK;
        ST_ACK:       if (fall) state_nxt = ST_WAIT_IDLE;
        ST_WAIT_IDLE: if (line_idle) state_nxt = ST_IDLE;
        default:      state_nxt = ST_IDLE;
      endcase
    end
  end

  // Open-collector drives decoded from state; reset releases the bus at once.
  always_comb begin
    ps2_clk_oe  = (state == ST_INHIBIT) || (state == ST_REQ);
    ps2_data_oe = (state == ST_REQ) || ((state == ST_SHIFT) && data_bit);
  end

  // Bus registers, frame shifter and the shared inhibit/watchdog counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy      <= 1'b1;
      ien      <= 1'b0;
      err      <= 1'b0;
      data_q   <= '0;
      shreg    <= '1;
      bitcnt   <= '0;
      data_bit <= 1'b0;
      cnt      <= '0;
    end else begin
      if (ctrl_wr) begin
        ien <= data_in[BIT_IEN];
        if (data_in[BIT_ERR]) err <= 1'b0;
      end

      unique case (state)
        ST_INHIBIT: cnt <= cnt + 1'b1;
        ST_REQ: begin
          cnt      <= '0;
          bitcnt   <= '0;
          data_bit <= 1'b1;
        end
        ST_SHIFT, ST_ACK, ST_WAIT_IDLE: cnt <= fall ? '0 : cnt + 1'b1;
        default: cnt <= '0;
      endcase

      if (accept) begin
        data_q <= data_in;
        shreg  <= {1'b1, odd_parity(data_in), data_in};
        rdy    <= 1'b0;
        err    <= 1'b0;
      end

      if ((state == ST_SHIFT) && fall) begin
        data_bit <= ~shreg[0];
        shreg    <= {1'b0, shreg[9:1]};
        bitcnt   <= bitcnt + 4'd1;
      end

      if ((state == ST_ACK) && fall && sync_data) err <= 1'b1;

      if ((state == ST_WAIT_IDLE) && line_idle) rdy <= 1'b1;

      // Placed last so an abort wins over a same-cycle software err clear.
      if (timeout) begin
        err <= 1'b1;
        rdy <= 1'b1;
      end
    end
  end

  // Register read mux.
  always_comb begin
    data_out = '0;
    if (addr == ADDR_DATA) begin
      data_out = data_q;
    end else begin
      data_out[BIT_RDY] = rdy;
      data_out[BIT_IEN] = ien;
      data_out[BIT_ERR] = err;
    end
  end

  assign ack     = stb;
  assign irq     = ien & rdy;
  assign tx_busy = ~rdy;

endmodule

// File: tb/tb_kbd_tx.sv
// Scoreboard bench for kbd_tx with a behavioural PS/2 keyboard on the wire.
module tb_kbd_tx;

  localparam int unsigned INH  = 50;
  localparam int unsigned TMO  = 600;
  localparam int unsigned HALF = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       stb, we, addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       ack, irq;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       tx_busy;

  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;

  // Wired-AND open-collector bus with pull-ups.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  kbd_tx #(
    .INHIBIT_CYC(INH),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stb        (stb),
    .we         (we),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .ack        (ack),
    .irq        (irq),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_busy    (tx_busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    logic       par;
    bit         chk_frame;
    bit         chk_tmo;
    logic [7:0] status;
    logic       irq_e;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Device model state: 0 normal, 1 no ack, 2 stop clocking after 4 bits.
  int          dev_mode = 0;
  int          dev_falls = 0;
  int          cap_inh = 0;
  logic        cap_start;
  logic [9:0]  cap_bits;
  int unsigned last_fall_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Keyboard: times the inhibit, samples on rising edges, acks on the 11th clock.
  initial begin
    forever begin
      int n;
      @(posedge ps2_clk_oe);
      dev_falls = 0;
      cap_bits  = '0;
      n = 0;
      @(negedge clk);
      while (ps2_clk_oe === 1'b1) begin
        n++;
        @(negedge clk);
      end
      cap_inh   = n;
      cap_start = ps2_data_in;
      repeat (HALF) @(negedge clk);
      for (int k = 1; k <= 11; k++) begin
        if (dev_mode == 2 && k > 4) break;
        dev_clk_low   = 1'b1;
        last_fall_cyc = cyc;
        dev_falls++;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        if (k <= 10) cap_bits[k-1] = ps2_data_in;
        if (k == 10 && dev_mode == 0) dev_data_low = 1'b1;
        if (k == 11) dev_data_low = 1'b0;
        repeat (HALF) @(negedge clk);
      end
    end
  end

  // Monitor: every return to ready pops one expected transaction.
  initial begin
    logic prev_busy;
    exp_t e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && prev_busy === 1'b1 && tx_busy === 1'b0) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_completion: got completion expected none");
        end else begin
          e = sb.pop_front();
          chk("status", 32'(data_out), 32'(e.status));
          chk("irq", 32'(irq), 32'(e.irq_e));
          chk("oe_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'h0);
          if (e.chk_frame) begin
            chk("inhibit_len", 32'(cap_inh), 32'(INH + 1));
            chk("start_bit", 32'(cap_start), 32'h0);
            chk("frame_data", 32'(cap_bits[7:0]), 32'(e.b));
            chk("frame_parity", 32'(cap_bits[8]), 32'(e.par));
            chk("frame_stop", 32'(cap_bits[9]), 32'h1);
          end
          if (e.chk_tmo) begin
            tests++;
            if ((cyc - last_fall_cyc) < TMO || (cyc - last_fall_cyc) > TMO + 10) begin
              fails++;
              $display("FAIL timeout_delay: got %0d cycles expected %0d..%0d",
                       cyc - last_fall_cyc, TMO, TMO + 10);
            end
          end
        end
      end
      prev_busy = tx_busy;
    end
  end

  task automatic bus_write(input logic a, input logic [7:0] d, input bit expect_accept);
    @(negedge clk);
    stb = 1'b1; we = 1'b1; addr = a; data_in = d;
    #1;
    chk("ack", 32'(ack), 32'h1);
    @(posedge clk);
    #1;
    if (expect_accept) begin
      chk("accept_busy", 32'(tx_busy), 32'h1);
      chk("accept_clk_oe", 32'(ps2_clk_oe), 32'h1);
    end
    stb = 1'b0; we = 1'b0; addr = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic par, input int mode,
                      input logic [7:0] status, input logic irq_e,
                      input bit frame, input bit tmo);
    exp_t e;
    e.b = b; e.par = par; e.chk_frame = frame; e.chk_tmo = tmo;
    e.status = status; e.irq_e = irq_e;
    dev_mode = mode;
    sb.push_back(e);
    bus_write(1'b1, b, 1'b1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    repeat (2 * HALF + 5) @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1; stb = 1'b0; we = 1'b0; addr = 1'b0; data_in = 8'h00;
    #1;
    chk("reset_status", 32'(data_out), 32'h01);
    chk("reset_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    chk("reset_busy", 32'(tx_busy), 32'h0);
    addr = 1'b1;
    #1;
    chk("reset_data", 32'(data_out), 32'h00);
    addr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 0xED: six ones -> odd parity 1.
    send(8'hED, 1'b1, 0, 8'h01, 1'b0, 1'b1, 1'b0);
    wait_drain();

    // Parity corners.
    send(8'h00, 1'b1, 0, 8'h01, 1'b0, 1'b1, 1'b0);
    wait_drain();
    send(8'h01, 1'b0, 0, 8'h01, 1'b0, 1'b1, 1'b0);
    wait_drain();

    // Missing ack -> err=1, rdy=1 -> 0x05.
    send(8'hFF, 1'b1, 1, 8'h05, 1'b0, 1'b1, 1'b0);
    wait_drain();

    // Clear err, enable irq.
    bus_write(1'b0, 8'h06, 1'b0);
    chk("ctrl_status", 32'(data_out), 32'h03);
    chk("ctrl_irq", 32'(irq), 32'h1);

    // Device stalls after 4 bits -> watchdog abort, 0x07 with irq.
    send(8'hF3, 1'b0, 2, 8'h07, 1'b1, 1'b0, 1'b1);
    wait_drain();

    // Write while busy is dropped.
    send(8'hF4, 1'b0, 0, 8'h03, 1'b1, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    chk("busy_irq", 32'(irq), 32'h0);
    bus_write(1'b1, 8'h55, 1'b0);
    chk("busy_still", 32'(tx_busy), 32'h1);
    @(negedge clk);
    addr = 1'b1;
    #1;
    chk("busy_data_reg", 32'(data_out), 32'hF4);
    addr = 1'b0;
    wait_drain();

    // Reset in the middle of SHIFT.
    dev_falls = 0;
    bus_write(1'b1, 8'hAA, 1'b1);
    dev_mode = 2;
    n = 0;
    while (dev_falls < 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("shift_reached", 32'(dev_falls >= 3), 32'h1);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'h0);
    chk("midreset_status", 32'(data_out), 32'h01);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4 * HALF) @(negedge clk);

    // Recovery after reset: 0x12 has two ones -> parity 1.
    send(8'h12, 1'b1, 0, 8'h01, 1'b0, 1'b1, 1'b0);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
